// File: rtl/dac_seg_encoder.sv
// rtl/dac_seg_encoder.sv - 12-bit sample to segmented DAC binary/thermometer encoder with DWA and power sequencing
//
// Pipeline: stage 1 clips and selects the code (live, held or forced zero),
// stage 2 maps the MSBs onto thermometer elements (optionally rotated by the
// DWA pointer), and the output register drives true and complement buses
// from the same edge.
//
// Ports:
//   clkin        in   DAC sample clock, rising edge
//   rst          in   synchronous active-high reset
//   din          in   unsigned input sample
//   din_valid    in   din is valid this cycle
//   dwa_en       in   1 = rotate thermometer elements, 0 = fixed order
//   pd_req       in   1 = request DAC power-down
//   datainbin    out  binary LSB segment
//   datainbinb   out  complement of datainbin
//   dataintherm  out  thermometer MSB elements
//   datainthermb out  complement of dataintherm
//   pdb          out  DAC enable, 0 = powered down
//   sat_flag     out  sample on the outputs was clipped
//   underrun     out  sample on the outputs is a reissue caused by din_valid = 0

module dac_seg_encoder #(
    parameter int NBIN     = 7,
    parameter int NTHERM   = 17,
    parameter int CODE_W   = 12,
    parameter int WAKE_CYC = 4
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [CODE_W-1:0] din,
    input  logic              din_valid,
    input  logic              dwa_en,
    input  logic              pd_req,
    output logic [NBIN-1:0]   datainbin,
    output logic [NBIN-1:0]   datainbinb,
    output logic [NTHERM-1:0] dataintherm,
    output logic [NTHERM-1:0] datainthermb,
    output logic              pdb,
    output logic              sat_flag,
    output logic              underrun
);

    localparam int FS = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;
    localparam int KW = CODE_W - NBIN;
    localparam int PW = $clog2(NTHERM);
    localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          dcnt_q, dcnt_d;
    logic          pdb_q, pdb_d;

    logic [CODE_W-1:0] hold_q, hold_d;
    logic [CODE_W-1:0] code1_q, code1_d;
    logic              sat1_q, sat1_d;
    logic              und1_q, und1_d;
    logic              frc1_q, frc1_d;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NBIN-1:0]   bin2_q, bin2_d;
    logic [NTHERM-1:0] therm2_q, therm2_d;
    logic              sat2_q, sat2_d;
    logic              und2_q, und2_d;

    logic [NBIN-1:0]   datainbin_q, datainbin_d;
    logic [NBIN-1:0]   datainbinb_q, datainbinb_d;
    logic [NTHERM-1:0] dataintherm_q, dataintherm_d;
    logic [NTHERM-1:0] datainthermb_q, datainthermb_d;
    logic              sat_flag_q, sat_flag_d;
    logic              underrun_q, underrun_d;

    // Power sequencing. DRAIN always lasts two cycles; pd_req is not
    // looked at again until OFF.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
        pdb_d   = pdb_q;
        case (state_q)
            ST_OFF: begin
                if (!pd_req) begin
                    state_d = ST_WAKE;
                    wcnt_d  = WW'(WAKE_CYC - 1);
                    pdb_d   = 1'b1;
                end
            end
            ST_WAKE: begin
                if (pd_req) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = 1'b1;
                end else if (wcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (pd_req) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == 1'b0) begin
                    state_d = ST_OFF;
                    pdb_d   = 1'b0;
                end else begin
                    dcnt_d = 1'b0;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Stage 1. The sample taken on the edge that leaves RUN is already a
    // forced zero, so by the time DRAIN ends the zero code sits on the
    // outputs.
    logic              run_sample;
    logic [CODE_W-1:0] src;

    always_comb begin
        run_sample = (state_q == ST_RUN) && !pd_req;
        src        = din_valid ? din : hold_q;
        hold_d     = hold_q;
        code1_d    = '0;
        sat1_d     = 1'b0;
        und1_d     = 1'b0;
        frc1_d     = !run_sample;
        if (run_sample) begin
            if (din_valid) begin
                hold_d = din;
            end
            und1_d = !din_valid;
            if (src > CODE_W'(FS)) begin
                code1_d = CODE_W'(FS);
                sat1_d  = 1'b1;
            end else begin
                code1_d = src;
            end
        end
    end

    // Stage 2. The thermometer mask is rotated left by the pointer using a
    // double-width shift whose upper half is folded back onto the lower.
    logic [KW-1:0]       k;
    logic [PW-1:0]       base;
    logic [NTHERM-1:0]   mask;
    logic [2*NTHERM-1:0] rot;
    logic [PW:0]         psum;

    always_comb begin
        k    = code1_q[CODE_W-1:NBIN];
        base = dwa_en ? ptr_q : '0;
        if (int'(k) >= NTHERM) begin
            mask = '1;
        end else begin
            mask = (NTHERM'(1) << k) - NTHERM'(1);
        end
        rot      = {{NTHERM{1'b0}}, mask} << base;
        therm2_d = rot[NTHERM-1:0] | rot[2*NTHERM-1:NTHERM];
        bin2_d   = code1_q[NBIN-1:0];
        sat2_d   = sat1_q;
        und2_d   = und1_q;

        psum = {1'b0, ptr_q} + (PW+1)'(k);
        if (int'(psum) >= NTHERM) begin
            psum = psum - (PW+1)'(NTHERM);
        end
        if (frc1_q) begin
            ptr_d = ptr_q;
        end else if (!dwa_en) begin
            ptr_d = '0;
        end else begin
            ptr_d = psum[PW-1:0];
        end
    end

    always_comb begin
        datainbin_d    = bin2_q;
        datainbinb_d   = ~bin2_q;
        dataintherm_d  = therm2_q;
        datainthermb_d = ~therm2_q;
        sat_flag_d     = sat2_q;
        underrun_d     = und2_q;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q        <= ST_OFF;
            wcnt_q         <= '0;
            dcnt_q         <= 1'b0;
            pdb_q          <= 1'b0;
            hold_q         <= '0;
            code1_q        <= '0;
            sat1_q         <= 1'b0;
            und1_q         <= 1'b0;
            frc1_q         <= 1'b1;
            ptr_q          <= '0;
            bin2_q         <= '0;
            therm2_q       <= '0;
            sat2_q         <= 1'b0;
            und2_q         <= 1'b0;
            datainbin_q    <= '0;
            datainbinb_q   <= '1;
            dataintherm_q  <= '0;
            datainthermb_q <= '1;
            sat_flag_q     <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            dcnt_q         <= dcnt_d;
            pdb_q          <= pdb_d;
            hold_q         <= hold_d;
            code1_q        <= code1_d;
            sat1_q         <= sat1_d;
            und1_q         <= und1_d;
            frc1_q         <= frc1_d;
            ptr_q          <= ptr_d;
            bin2_q         <= bin2_d;
            therm2_q       <= therm2_d;
            sat2_q         <= sat2_d;
            und2_q         <= und2_d;
            datainbin_q    <= datainbin_d;
            datainbinb_q   <= datainbinb_d;
            dataintherm_q  <= dataintherm_d;
            datainthermb_q <= datainthermb_d;
            sat_flag_q     <= sat_flag_d;
            underrun_q     <= underrun_d;
        end
    end

    assign datainbin    = datainbin_q;
    assign datainbinb   = datainbinb_q;
    assign dataintherm  = dataintherm_q;
    assign datainthermb = datainthermb_q;
    assign pdb          = pdb_q;
    assign sat_flag     = sat_flag_q;
    assign underrun     = underrun_q;

endmodule

// File: doc/dac_seg_encoder.md
Name: dac_seg_encoder

Overview:
- Digital front-end directly upstream of the segmented current-steering DAC top level.
- Converts a 12-bit unsigned sample stream into the DAC's 7-bit binary LSB bus and 17-element thermometer MSB bus, with complementary copies of both.
- Applies saturation and optional data-weighted-averaging (DWA) rotation of the thermometer elements.
- Sequences the DAC power-down pin `pdb`.

Parameters:
- NBIN, 7, binary LSB segment width.
- NTHERM, 17, number of unary thermometer elements.
- CODE_W, 12, input sample width.
- WAKE_CYC, 4, cycles that outputs are held at zero code after `pdb` rises.

Ports:
- clkin  in  1  DAC sample clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- din  in  CODE_W  unsigned input sample.
- din_valid  in  1  `din` is valid this cycle.
- dwa_en  in  1  1 = DWA rotation enabled; 0 = fixed element order.
- pd_req  in  1  1 = request DAC power-down.
- datainbin  out  NBIN  binary segment; bit i has weight 2^i.
- datainbinb  out  NBIN  bitwise complement of `datainbin`.
- dataintherm  out  NTHERM  thermometer elements; each element has weight 2^NBIN.
- datainthermb  out  NTHERM  bitwise complement of `dataintherm`.
- pdb  out  1  DAC enable; 0 = powered down.
- sat_flag  out  1  registered: the sample now on the outputs was clipped.
- underrun  out  1  registered: a cycle in RUN had `din_valid` = 0.

Behaviour:
- Reset (`rst` = 1 at a rising edge):
  - `datainbin` = 0, `dataintherm` = 0, both complement buses = all ones.
  - `pdb` = 0, `sat_flag` = 0, `underrun` = 0.
  - DWA pointer = 0, hold register = 0, state = OFF, pipeline cleared.
  - Reset mid-operation takes effect on the next edge regardless of state.
- Full scale: FS = NTHERM*2^NBIN + 2^NBIN − 1 = 2303.
  - Stage 1 clips: `din` > FS → code = FS and sat bit = 1.
  - Split: k = code >> NBIN (0..17), b = code[NBIN-1:0].
- Stage 2 (thermometer mapping):
  - dwa_en = 0: elements 0..k-1 on; pointer forced to 0.
  - dwa_en = 1: elements (p+j) mod NTHERM on for j = 0..k-1.
  - Pointer update: p ← (p+k) mod NTHERM.
  - k = 0: no elements on, p unchanged.
  - k = 17: all elements on, p unchanged.
- Output register: complements are registered in the same cycle as the true outputs and are never skewed from them.
- Latency: a valid `din` at edge n appears on the outputs after edge n+2.
- `din_valid` = 0 in RUN:
  - The last valid code is reissued through the pipeline; DWA still rotates by its k.
  - `underrun` = 1 for the corresponding output cycle.
- State machine (evaluated each edge after reset):
  - OFF: `pdb` = 0, pipeline input forced to code 0. pd_req = 0 → WAKE, with `pdb` = 1 from that edge and wake counter = WAKE_CYC−1.
  - WAKE: `pdb` = 1, code forced to 0. Counter reaches 0 → RUN. pd_req = 1 → DRAIN.
  - RUN: normal encoding. pd_req = 1 → DRAIN.
  - DRAIN: code forced to 0 for 2 cycles so zero code reaches the outputs, then → OFF with `pdb` = 0. pd_req deasserting during DRAIN is ignored until OFF.
- Forced-zero codes (OFF, WAKE, DRAIN):
  - Pointer held, `sat_flag` = 0, `underrun` = 0.
  - Samples presented in these states are discarded, not queued.

Test Plan:
- Reset, then pd_req = 0 → `pdb` rises 1 cycle after reset release; outputs stay zero code (`datainbinb` = 7'h7F, `datainthermb` = 17'h1FFFF) for WAKE_CYC cycles, then RUN.
- dwa_en = 0, din = 0x2A5 (677): after 2 cycles `datainbin` = 0x25, `dataintherm` = 17'h0001F (k = 5); the complement buses match.
- din = 0xFFF → `sat_flag` = 1, `datainbin` = 0x7F, `dataintherm` = 17'h1FFFF. din = 2303 → `sat_flag` = 0, same outputs.
- dwa_en = 1, three samples with k = 10 each (din = 1280):
  - sample 1: elements 0–9, p = 10;
  - sample 2: elements 10–16 and 0–2, p = 3;
  - sample 3: elements 3–12, p = 13.
- Drop `din_valid` for 2 cycles in RUN after din = 300 → code 300 is repeated and `underrun` = 1 for exactly 2 output cycles.
- Assert pd_req in RUN → 2 cycles of zero code, then `pdb` = 0. Pulse `rst` while in WAKE → all outputs return to reset values on the next edge.
